// File: rtl/proc_define.sv
// proc_define: shared processor definitions.
// Holds the RV32 opcode constants used by the decode stage, the arith
// function encodings, and the decoded-instruction record with its helper.
package proc_define;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [2:0] F3_ADD = 3'b000;

  localparam logic [2:0] ARITH_ADD = 3'b000;
  localparam logic [2:0] ARITH_SUB = 3'b001;

  // Result of decoding one instruction word.
  typedef struct packed {
    logic        legal;     // encoding is one of ADD/SUB/ADDI/LUI
    logic [2:0]  funct;     // arith function
    logic        op1_zero;  // op1 is the constant 0 (LUI)
    logic        use_imm;   // op2 comes from imm, not rs2
    logic [31:0] imm;       // immediate already extended/shifted
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[6:0])
      OPC_OP: begin
        if (instr[14:12] == F3_ADD && instr[31:25] == F7_ADD) begin
          d.legal = 1'b1;
          d.funct = ARITH_ADD;
        end else if (instr[14:12] == F3_ADD && instr[31:25] == F7_SUB) begin
          d.legal = 1'b1;
          d.funct = ARITH_SUB;
        end
      end
      OPC_OP_IMM: begin
        if (instr[14:12] == F3_ADD) begin
          d.legal   = 1'b1;
          d.funct   = ARITH_ADD;
          d.use_imm = 1'b1;
          d.imm     = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI: begin
        d.legal    = 1'b1;
        d.funct    = ARITH_ADD;
        d.op1_zero = 1'b1;
        d.use_imm  = 1'b1;
        d.imm      = {instr[31:12], 12'b0};
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32 x 32-bit integer register file.
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   raddr1_i / rdata1_o   combinational read port 1
//   raddr2_i / rdata2_o   combinational read port 2
//   we_i, waddr_i, wdata_i  write port, written on the rising edge
// x0 always reads 0 and writes to it are dropped. Reset clears every entry.
module regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] mem [32];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32 decode for ADD/SUB/ADDI/LUI with a one-entry output
// register toward the arith stage.
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   instr_valid_i/instr_i/instr_ready_o   instruction input handshake
//   wb_en_i/wb_rd_i/wb_data_i       register writeback (every cycle, never stalled)
//   ex_valid_o/ex_ready_i           op output handshake
//   funct_o/op1_o/op2_o/rd_o        decoded op payload
//   illegal_o                       one-cycle pulse after an unsupported word is consumed
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and payload until the transfer; the payload of an
// asserted ex_valid_o stays frozen until ex_ready_i is seen. instr_ready_o is
// high whenever the output slot is empty or being drained this cycle.
module decode_stage
  import proc_define::*;
(
  input  logic        rst_n_i,
  input  logic        clk_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [2:0]  funct_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  logic [4:0]  rs1, rs2;
  logic [31:0] rf_rs1, rf_rs2;
  logic [31:0] rs1_val, rs2_val;
  logic        accept;
  dec_t        dec;

  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign dec = decode_instr(instr_i);

  regfile u_regfile (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .raddr1_i (rs1),
    .rdata1_o (rf_rs1),
    .raddr2_i (rs2),
    .rdata2_o (rf_rs2),
    .we_i     (wb_en_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i)
  );

  // A writeback landing on the same edge as the operand capture would be
  // missed by the array read, so forward it here. x0 is never forwarded.
  assign rs1_val = (wb_en_i && wb_rd_i == rs1 && rs1 != 5'd0) ? wb_data_i : rf_rs1;
  assign rs2_val = (wb_en_i && wb_rd_i == rs2 && rs2 != 5'd0) ? wb_data_i : rf_rs2;

  assign instr_ready_o = !ex_valid_o || ex_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_o <= 1'b0;
      funct_o    <= '0;
      op1_o      <= '0;
      op2_o      <= '0;
      rd_o       <= '0;
      illegal_o  <= 1'b0;
    end else begin
      illegal_o <= accept && !dec.legal;
      if (accept && dec.legal) begin
        // Load also covers consume-and-accept on the same edge (no bubble).
        ex_valid_o <= 1'b1;
        funct_o    <= dec.funct;
        op1_o      <= dec.op1_zero ? 32'd0 : rs1_val;
        op2_o      <= dec.use_imm ? dec.imm : rs2_val;
        rd_o       <= instr_i[11:7];
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table-driven bench for decode_stage.
module tb_decode_stage;

  logic        rst_n_i;
  logic        clk_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [2:0]  funct_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .rst_n_i       (rst_n_i),
    .clk_i         (clk_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .wb_en_i       (wb_en_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .funct_o       (funct_o),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .rd_o          (rd_o),
    .illegal_o     (illegal_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    chk({name, ".valid"}, {31'd0, ex_valid_o}, 32'd1);
    chk({name, ".funct"}, {29'd0, funct_o}, {29'd0, f});
    chk({name, ".op1"}, op1_o, a);
    chk({name, ".op2"}, op2_o, b);
    chk({name, ".rd"}, {27'd0, rd_o}, {27'd0, rd});
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".valid"}, {31'd0, ex_valid_o}, 32'd0);
    chk({name, ".funct"}, {29'd0, funct_o}, 32'd0);
    chk({name, ".op1"}, op1_o, 32'd0);
    chk({name, ".op2"}, op2_o, 32'd0);
    chk({name, ".rd"}, {27'd0, rd_o}, 32'd0);
    chk({name, ".illegal"}, {31'd0, illegal_o}, 32'd0);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    wb_en_i = 1'b1; wb_rd_i = rd; wb_data_i = data;
    step();
    wb_en_i = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic        illegal;
    logic [2:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[9];

  // Scoreboard of rd values for the back-to-back run.
  logic [4:0] exp_q[$];

  initial begin
    rst_n_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0;
    wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;

    // Vectors assume x1=5, x2=3, applied back-to-back with ex_ready_i=1.
    vecs[0] = '{"add_x3", enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, 3'b000, 32'd5, 32'd3, 5'd3};
    vecs[1] = '{"sub_x4", enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 1, 0, 3'b001, 32'd5, 32'd3, 5'd4};
    vecs[2] = '{"addi_m1", enc_i(12'hFFF, 5'd0, 3'b000, 5'd5), 1, 0, 3'b000, 32'd0, 32'hFFFFFFFF, 5'd5};
    vecs[3] = '{"lui", enc_u(20'hABCDE, 5'd6), 1, 0, 3'b000, 32'd0, 32'hABCDE000, 5'd6};
    vecs[4] = '{"zero_word", 32'h00000000, 0, 1, 3'b000, 32'd0, 32'd0, 5'd0};
    vecs[5] = '{"addi_12", enc_i(12'd12, 5'd2, 3'b000, 5'd8), 1, 0, 3'b000, 32'd3, 32'd12, 5'd8};
    vecs[6] = '{"f3_bad", enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd9), 0, 1, 3'b000, 32'd0, 32'd0, 5'd0};
    vecs[7] = '{"slti_bad", enc_i(12'd1, 5'd1, 3'b010, 5'd9), 0, 1, 3'b000, 32'd0, 32'd0, 5'd0};
    vecs[8] = '{"add_x9", enc_r(7'h00, 5'd1, 5'd2, 3'b000, 5'd9), 1, 0, 3'b000, 32'd3, 32'd5, 5'd9};

    // ---- reset state ----
    #12;
    chk_zero("reset");
    chk("reset.ready", {31'd0, instr_ready_o}, 32'd1);
    rst_n_i = 1'b1;
    step();
    chk("post_rst.ready", {31'd0, instr_ready_o}, 32'd1);

    // ---- register setup ----
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);

    // ---- table: back-to-back accepts, one per cycle ----
    for (int i = 0; i < 9; i++) begin
      instr_valid_i = 1'b1; instr_i = vecs[i].instr; ex_ready_i = 1'b1;
      #1;
      chk({vecs[i].name, ".ready"}, {31'd0, instr_ready_o}, 32'd1);
      step();
      chk({vecs[i].name, ".valid"}, {31'd0, ex_valid_o}, {31'd0, vecs[i].valid});
      chk({vecs[i].name, ".illegal"}, {31'd0, illegal_o}, {31'd0, vecs[i].illegal});
      if (vecs[i].valid) chk_op(vecs[i].name, vecs[i].funct, vecs[i].op1, vecs[i].op2, vecs[i].rd);
    end
    instr_valid_i = 1'b0;
    step();
    chk("idle.valid", {31'd0, ex_valid_o}, 32'd0);
    chk("idle.illegal", {31'd0, illegal_o}, 32'd0);

    // ---- illegal pulse is exactly one cycle ----
    instr_valid_i = 1'b1; instr_i = 32'h0;
    step();
    instr_valid_i = 1'b0;
    chk("ill1.pulse", {31'd0, illegal_o}, 32'd1);
    chk("ill1.valid", {31'd0, ex_valid_o}, 32'd0);
    step();
    chk("ill1.after", {31'd0, illegal_o}, 32'd0);

    // ---- stall: SUB x4 held for 3 cycles, later writeback must not leak ----
    ex_ready_i = 1'b0;
    instr_valid_i = 1'b1; instr_i = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
    step();
    instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd10);  // waits upstream
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall.ready", {31'd0, instr_ready_o}, 32'd0);
      chk_op("stall", 3'b001, 32'd5, 32'd3, 5'd4);
      if (c == 0) wb(5'd1, 32'd100); else step();
    end
    chk_op("stall_end", 3'b001, 32'd5, 32'd3, 5'd4);
    // Ready cycle: SUB retires and the waiting ADD x10 loads with no bubble.
    ex_ready_i = 1'b1;
    #1;
    chk("retire.ready", {31'd0, instr_ready_o}, 32'd1);
    step();
    chk_op("replace", 3'b000, 32'd100, 32'd3, 5'd10);
    instr_valid_i = 1'b0;
    step();
    chk("retire.valid", {31'd0, ex_valid_o}, 32'd0);

    // ---- bypass: ADD x7,x1,x1 with writeback x1=9 on the same edge ----
    instr_valid_i = 1'b1; instr_i = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd7);
    wb(5'd1, 32'd9);
    chk_op("bypass", 3'b000, 32'd9, 32'd9, 5'd7);
    // Same-edge write to x0 must not be forwarded.
    instr_i = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd13);
    wb(5'd0, 32'd7);
    chk_op("x0_bypass", 3'b000, 32'd0, 32'd0, 5'd13);
    instr_valid_i = 1'b0;
    wb(5'd0, 32'd7);
    instr_valid_i = 1'b1; instr_i = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd12);
    step();
    chk_op("x0_read", 3'b000, 32'd0, 32'd0, 5'd12);
    // Register file still holds x1=9 from the bypassed write.
    instr_i = enc_i(12'd1, 5'd1, 3'b000, 5'd11);
    step();
    chk_op("x1_stored", 3'b000, 32'd9, 32'd1, 5'd11);
    instr_valid_i = 1'b0;
    step();

    // ---- streaming with scoreboard: ADDI x(16+k), x2, k ----
    for (int k = 0; k < 6; k++) begin
      instr_valid_i = 1'b1; instr_i = enc_i(12'(k), 5'd2, 3'b000, 5'(16 + k));
      exp_q.push_back(5'(16 + k));
      step();
      chk("stream.valid", {31'd0, ex_valid_o}, 32'd1);
      if (exp_q.size() > 0) chk("stream.rd", {27'd0, rd_o}, {27'd0, exp_q.pop_front()});
      chk("stream.op2", op2_o, 32'(k));
    end
    instr_valid_i = 1'b0;
    step();

    // ---- reset pulsed mid-stall ----
    ex_ready_i = 1'b0;
    instr_valid_i = 1'b1; instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd15);
    step();
    instr_valid_i = 1'b0;
    chk_op("pre_rst", 3'b000, 32'd9, 32'd3, 5'd15);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_zero("async_rst");
    step();
    rst_n_i = 1'b1;
    #1;
    chk("rel.ready", {31'd0, instr_ready_o}, 32'd1);
    // Register file was cleared by reset: x1 and x2 read 0.
    ex_ready_i = 1'b1;
    instr_valid_i = 1'b1; instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd14);
    step();
    instr_valid_i = 1'b0;
    chk_op("rf_cleared", 3'b000, 32'd0, 32'd0, 5'd14);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
